// File: rtl/bl_write_sequencer.sv
// bl_write_sequencer
//   Command-driven sequencer for the 32-cell bit-line interface. It loads the
//   8-channel op-voltage DAC, waits SETTLE_CYC cycles, and then pulses
//   o_bl_pre_op_en (PRELOAD) or o_bl_addr_en (SINGLE/SWEEP) for PULSE_CYC
//   cycles, with a stable o_addr. Only one command executes at a time.
//
// Optional feature macro: BL_SEQ_ABORT_EN
//   When it is defined, the module has an i_abort input. Asserting i_abort
//   in an active state ends the command with done+err. Any enable pulse in
//   progress is cut short.
//
// Ports
//   i_clk, i_rst_n     clock; synchronous active-low reset
//   i_cmd_valid/op/addr/len/code, o_cmd_ready   command handshake
//   i_abort            (BL_SEQ_ABORT_EN only) abort the running command
//   o_dac_we/ch/code   DAC channel write strobe, channel and code
//   o_bl_pre_op_en     preload all cells
//   o_bl_addr_en       write the single cell at o_addr
//   o_addr             cell address
//   o_busy             state is not IDLE
//   o_done/o_err       one-cycle completion pulse and rejection flag
module bl_write_sequencer #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned PULSE_CYC  = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [4:0] i_cmd_addr,
  input  logic [5:0] i_cmd_len,
  input  logic [7:0] i_cmd_code,
`ifdef BL_SEQ_ABORT_EN
  input  logic       i_abort,
`endif
  output logic       o_dac_we,
  output logic [2:0] o_dac_ch,
  output logic [7:0] o_dac_code,
  output logic       o_bl_pre_op_en,
  output logic       o_bl_addr_en,
  output logic [4:0] o_addr,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [1:0] OP_PRELOAD = 2'b01;
  localparam logic [1:0] OP_SINGLE  = 2'b10;
  localparam logic [1:0] OP_SWEEP   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_PULSE, S_NEXT, S_DONE
  } state_t;

  state_t           r_state;
  logic [1:0]       r_op;
  logic [5:0]       r_remain;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_ready;
  logic             r_dac_we;
  logic [2:0]       r_dac_ch;
  logic [7:0]       r_dac_code;
  logic             r_pre_en;
  logic             r_addr_en;
  logic [4:0]       r_addr;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_cmd_bad;
  logic             w_active;
  logic             w_abort;
  logic [4:0]       w_addr_inc;

  // A reserved op, or a SWEEP with zero length, is rejected without any strobes.
  assign w_cmd_bad  = (i_cmd_op == 2'b00) || ((i_cmd_op == OP_SWEEP) && (i_cmd_len == 6'd0));
  assign w_active   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_addr_inc = r_addr + 5'd1;

`ifdef BL_SEQ_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_remain    <= 6'd0;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_dac_we    <= 1'b0;
      r_dac_ch    <= 3'd0;
      r_dac_code  <= 8'd0;
      r_pre_en    <= 1'b0;
      r_addr_en   <= 1'b0;
      r_addr      <= 5'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort && w_active) begin
        // Abort drops every strobe at once, so a pulse can only get shorter.
        r_state   <= S_DONE;
        r_dac_we  <= 1'b0;
        r_pre_en  <= 1'b0;
        r_addr_en <= 1'b0;
        r_done    <= 1'b1;
        r_err     <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_cmd_valid && r_cmd_ready) begin
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
              r_op        <= i_cmd_op;
              r_remain    <= i_cmd_len;
              r_addr      <= i_cmd_addr;
              r_dac_code  <= i_cmd_code;
              if (w_cmd_bad) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_err   <= 1'b1;
              end else begin
                r_state  <= S_LOAD;
                r_dac_we <= 1'b1;
                r_dac_ch <= (i_cmd_op == OP_PRELOAD) ? 3'd0 : i_cmd_addr[2:0];
              end
            end
          end
          S_LOAD: begin
            // PRELOAD walks all 8 channels; the other ops write one channel.
            if ((r_op == OP_PRELOAD) && (r_dac_ch != 3'd7)) begin
              r_dac_ch <= r_dac_ch + 3'd1;
            end else begin
              r_dac_we <= 1'b0;
              r_cnt    <= CNT_W'(SETTLE_CYC - 1);
              r_state  <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_cnt == '0) begin
              r_state <= S_PULSE;
              r_cnt   <= CNT_W'(PULSE_CYC - 1);
              if (r_op == OP_PRELOAD) begin
                r_pre_en <= 1'b1;
              end else begin
                r_addr_en <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_PULSE: begin
            if (r_cnt == '0) begin
              r_pre_en  <= 1'b0;
              r_addr_en <= 1'b0;
              // The last sweep cell goes straight to DONE, so NEXT only appears between cells.
              if ((r_op == OP_SWEEP) && (r_remain > 6'd1)) begin
                r_remain <= r_remain - 6'd1;
                r_state  <= S_NEXT;
              end else begin
                r_remain <= 6'd0;
                r_state  <= S_DONE;
                r_done   <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          S_NEXT: begin
            // The address advances only after the enable has fallen.
            r_addr   <= w_addr_inc;
            r_dac_ch <= w_addr_inc[2:0];
            r_dac_we <= 1'b1;
            r_state  <= S_LOAD;
          end
          S_DONE: begin
            r_state     <= S_IDLE;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_cmd_ready    = r_cmd_ready;
  assign o_dac_we       = r_dac_we;
  assign o_dac_ch       = r_dac_ch;
  assign o_dac_code     = r_dac_code;
  assign o_bl_pre_op_en = r_pre_en;
  assign o_bl_addr_en   = r_addr_en;
  assign o_addr         = r_addr;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: tb/tb_bl_write_sequencer.sv
// Directed bench for bl_write_sequencer using the default parameters (SETTLE_CYC=4, PULSE_CYC=2).
// Cycle index k counts the samples taken on the negedge after the accept edge.
// k=0 is the first cycle after accept. Latency is done_k+1.
module tb_bl_write_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [4:0] cmd_addr = 5'd0;
  logic [5:0] cmd_len = 6'd0;
  logic [7:0] cmd_code = 8'd0;
  logic       dac_we;
  logic [2:0] dac_ch;
  logic [7:0] dac_code;
  logic       bl_pre_op_en;
  logic       bl_addr_en;
  logic [4:0] addr;
  logic       busy;
  logic       done;
  logic       err;
`ifdef BL_SEQ_ABORT_EN
  logic       abort = 1'b0;
`endif

  int n_cmp = 0;
  int n_mis = 0;

  logic [2:0] q_ch[$];
  logic [7:0] q_code[$];
  logic [4:0] q_ae_addr[$];
  int n_pre, pre_first, ae_first, done_k, overlap, rdy_busy;
  logic err_at_done;

  bl_write_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_code(cmd_code),
`ifdef BL_SEQ_ABORT_EN
    .i_abort(abort),
`endif
    .o_dac_we(dac_we), .o_dac_ch(dac_ch), .o_dac_code(dac_code),
    .o_bl_pre_op_en(bl_pre_op_en), .o_bl_addr_en(bl_addr_en), .o_addr(addr),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present one command at a negedge and let it be accepted at the next posedge.
  // cmd_valid then stays high with scrambled fields until done appears. This checks
  // that the captured fields are used and that nothing is accepted while busy.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] a,
                         input logic [5:0] len, input logic [7:0] code);
    q_ch.delete(); q_code.delete(); q_ae_addr.delete();
    n_pre = 0; pre_first = -1; ae_first = -1; done_k = -1;
    overlap = 0; rdy_busy = 0; err_at_done = 1'b0;
    @(negedge clk);
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = len; cmd_code = code;
    @(posedge clk);
    #1;
    cmd_op = 2'b00; cmd_addr = ~a; cmd_len = 6'd0; cmd_code = ~code;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (dac_we) begin q_ch.push_back(dac_ch); q_code.push_back(dac_code); end
      if (bl_addr_en) begin
        q_ae_addr.push_back(addr);
        if (ae_first < 0) ae_first = k;
      end
      if (bl_pre_op_en) begin
        n_pre++;
        if (pre_first < 0) pre_first = k;
      end
      if (bl_pre_op_en && bl_addr_en) overlap++;
      if (cmd_ready && busy) rdy_busy++;
      if (done) begin
        done_k = k; err_at_done = err;
        cmd_valid = 1'b0;
        break;
      end
    end
    @(negedge clk);
    check("ready_after_done", 32'(cmd_ready), 32'd1);
    check("idle_after_done", 32'({busy, done, err}), 32'd0);
  endtask

  initial begin
    // Reset: hold rst_n low for 3 cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_strobes", 32'({dac_we, bl_pre_op_en, bl_addr_en, busy, done, err}), 32'd0);
    check("rst_dac_ch", 32'(dac_ch), 32'd0);
    check("rst_dac_code", 32'(dac_code), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(cmd_ready), 32'd1);
    check("busy_after_release", 32'(busy), 32'd0);

    // SINGLE at addr 13 with code A5.
    run_cmd(2'b10, 5'd13, 6'd0, 8'hA5);
    check("single_latency", 32'(done_k + 1), 32'd8);
    check("single_err", 32'(err_at_done), 32'd0);
    check("single_n_we", 32'(q_ch.size()), 32'd1);
    if (q_ch.size() > 0) begin
      check("single_ch", 32'(q_ch[0]), 32'd5);
      check("single_code", 32'(q_code[0]), 32'hA5);
    end
    check("single_ae_first", 32'(ae_first), 32'd5);
    check("single_n_ae", 32'(q_ae_addr.size()), 32'd2);
    for (int i = 0; i < q_ae_addr.size(); i++) check("single_ae_addr", 32'(q_ae_addr[i]), 32'd13);
    check("single_n_pre", 32'(n_pre), 32'd0);
    check("single_ready_busy", 32'(rdy_busy), 32'd0);

    // PRELOAD with code 3C.
    run_cmd(2'b01, 5'd9, 6'd0, 8'h3C);
    check("pre_latency", 32'(done_k + 1), 32'd15);
    check("pre_n_we", 32'(q_ch.size()), 32'd8);
    for (int i = 0; i < q_ch.size(); i++) begin
      check("pre_ch", 32'(q_ch[i]), 32'(i));
      check("pre_code", 32'(q_code[i]), 32'h3C);
    end
    check("pre_first", 32'(pre_first), 32'd12);
    check("pre_n_pre", 32'(n_pre), 32'd2);
    check("pre_n_ae", 32'(q_ae_addr.size()), 32'd0);
    check("pre_err", 32'(err_at_done), 32'd0);

    // SWEEP from addr 30, length 4, wrapping 31 -> 0.
    run_cmd(2'b11, 5'd30, 6'd4, 8'h55);
    check("sweep_latency", 32'(done_k + 1), 32'd32);
    check("sweep_err", 32'(err_at_done), 32'd0);
    check("sweep_n_we", 32'(q_ch.size()), 32'd4);
    if (q_ch.size() == 4) begin
      check("sweep_ch0", 32'(q_ch[0]), 32'd6);
      check("sweep_ch1", 32'(q_ch[1]), 32'd7);
      check("sweep_ch2", 32'(q_ch[2]), 32'd0);
      check("sweep_ch3", 32'(q_ch[3]), 32'd1);
    end
    check("sweep_n_ae", 32'(q_ae_addr.size()), 32'd8);
    if (q_ae_addr.size() == 8) begin
      check("sweep_addr0", 32'(q_ae_addr[0]), 32'd30);
      check("sweep_addr1", 32'(q_ae_addr[1]), 32'd30);
      check("sweep_addr2", 32'(q_ae_addr[2]), 32'd31);
      check("sweep_addr3", 32'(q_ae_addr[3]), 32'd31);
      check("sweep_addr4", 32'(q_ae_addr[4]), 32'd0);
      check("sweep_addr6", 32'(q_ae_addr[6]), 32'd1);
    end
    check("sweep_overlap", 32'(overlap), 32'd0);
    check("sweep_ready_busy", 32'(rdy_busy), 32'd0);

    // Reserved op.
    run_cmd(2'b00, 5'd3, 6'd5, 8'h11);
    check("rsv_latency", 32'(done_k + 1), 32'd1);
    check("rsv_err", 32'(err_at_done), 32'd1);
    check("rsv_strobes", 32'(q_ch.size() + q_ae_addr.size() + n_pre), 32'd0);

    // SWEEP with length 0.
    run_cmd(2'b11, 5'd3, 6'd0, 8'h22);
    check("len0_latency", 32'(done_k + 1), 32'd1);
    check("len0_err", 32'(err_at_done), 32'd1);
    check("len0_strobes", 32'(q_ch.size() + q_ae_addr.size() + n_pre), 32'd0);

    // Reset during the first bl_addr_en cycle.
    begin
      int seen = 0;
      int dn = 0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 5'd7; cmd_code = 8'h77;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bl_addr_en) begin seen = 1; break; end
      end
      check("midrst_pulse_seen", 32'(seen), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_ae", 32'(bl_addr_en), 32'd0);
      check("midrst_state", 32'({busy, done, err, dac_we}), 32'd0);
      check("midrst_ready", 32'(cmd_ready), 32'd1);
      check("midrst_addr", 32'(addr), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (done) dn++;
      end
      check("midrst_no_done", 32'(dn), 32'd0);
    end

    // Recovery after the mid-command reset.
    run_cmd(2'b10, 5'd2, 6'd0, 8'h0F);
    check("recov_latency", 32'(done_k + 1), 32'd8);
    check("recov_n_ae", 32'(q_ae_addr.size()), 32'd2);

`ifdef BL_SEQ_ABORT_EN
    // Abort during SETTLE: done with err and no enable pulse.
    begin
      int dk = -1;
      int ae_n = 0;
      logic e = 1'b0;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 5'd4; cmd_code = 8'h44;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        abort = 1'b0;
        if (bl_addr_en) ae_n++;
        if (done) begin dk = k; e = err; break; end
      end
      check("abort_done_k", 32'(dk), 32'd0);
      check("abort_err", 32'(e), 32'd1);
      check("abort_no_pulse", 32'(ae_n), 32'd0);
      @(negedge clk);
      check("abort_ready", 32'(cmd_ready), 32'd1);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
